// File: rtl/noc_leaf_interface_if.sv
// ---------------------------------------------------------------------------
// noc_leaf_interface_if
// Handshake bundle between a PE, its leaf network interface and the parent
// router's child port.
//   pe_tx_*   : PE -> interface send request (valid/ready, dest, type, data)
//   net_out_* : interface -> router child input (valid/ready, 20-bit packet)
//   net_in_*  : router child output -> interface (valid/ready, 20-bit packet)
//   pe_rx_*   : interface -> PE receive (valid/ready, src, type, data)
//   drop_cnt  : saturating count of misrouted packets
// Modports: slave = the leaf interface itself, master = PE/router side.
// ---------------------------------------------------------------------------
interface noc_leaf_interface_if #(
    parameter int WIDTH_pack = 20,
    parameter int WIDTH_add  = 5,
    parameter int WIDTH_data = 8,
    parameter int WIDTH_type = 2
);
    logic                  pe_tx_valid;
    logic                  pe_tx_ready;
    logic [WIDTH_add-1:0]  pe_tx_dest;
    logic [WIDTH_type-1:0] pe_tx_type;
    logic [WIDTH_data-1:0] pe_tx_data;

    logic                  net_out_valid;
    logic                  net_out_ready;
    logic [WIDTH_pack-1:0] net_out_pack;

    logic                  net_in_valid;
    logic                  net_in_ready;
    logic [WIDTH_pack-1:0] net_in_pack;

    logic                  pe_rx_valid;
    logic                  pe_rx_ready;
    logic [WIDTH_add-1:0]  pe_rx_src;
    logic [WIDTH_type-1:0] pe_rx_type;
    logic [WIDTH_data-1:0] pe_rx_data;

    logic [7:0]            drop_cnt;

    modport slave (
        input  pe_tx_valid, pe_tx_dest, pe_tx_type, pe_tx_data,
        output pe_tx_ready,
        output net_out_valid, net_out_pack,
        input  net_out_ready,
        input  net_in_valid, net_in_pack,
        output net_in_ready,
        output pe_rx_valid, pe_rx_src, pe_rx_type, pe_rx_data,
        input  pe_rx_ready,
        output drop_cnt
    );

    modport master (
        output pe_tx_valid, pe_tx_dest, pe_tx_type, pe_tx_data,
        input  pe_tx_ready,
        input  net_out_valid, net_out_pack,
        output net_out_ready,
        output net_in_valid, net_in_pack,
        input  net_in_ready,
        input  pe_rx_valid, pe_rx_src, pe_rx_type, pe_rx_data,
        output pe_rx_ready,
        input  drop_cnt
    );
endinterface

// File: rtl/noc_leaf_interface.sv
// ---------------------------------------------------------------------------
// noc_leaf_interface
// Leaf network interface for the binary-tree NoC. Packetizes PE sends into
// {type, sender, receiver, data} packets through a TX FIFO toward the parent
// router, and filters/depacketizes router traffic through an RX FIFO toward
// the PE. Packets whose receiver field is not LOCAL_ADDR are handshaken,
// discarded and counted in drop_cnt (saturating at 255).
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : noc_leaf_interface_if.slave (pe_tx_*, net_out_*, net_in_*,
//           pe_rx_*, drop_cnt)
// Optional feature macro: NOC_LEAF_LOOPBACK_EN -- self-addressed TX packets
// bypass the network and are moved straight into the RX FIFO.
// ---------------------------------------------------------------------------

// Circular FIFO with wrap-around pointers and an occupancy counter.
module noc_leaf_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 20
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [DEPTH-1:0][W-1:0] mem;
    logic [PW-1:0]           wr_ptr, rd_ptr;
    logic [CW-1:0]           count;
    logic                    push_ok, pop_ok;

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign dout    = mem[rd_ptr];

    // Storage is not reset: occupancy decides what is visible.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= ptr_next(wr_ptr);
            if (pop_ok)  rd_ptr <= ptr_next(rd_ptr);
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

module noc_leaf_interface #(
    parameter int LOCAL_ADDR = 1,
    parameter int WIDTH_pack = 20,
    parameter int WIDTH_add  = 5,
    parameter int WIDTH_data = 8,
    parameter int WIDTH_type = 2,
    parameter int TX_DEPTH   = 4,
    parameter int RX_DEPTH   = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    noc_leaf_interface_if.slave  bus
);
    typedef struct packed {
        logic [WIDTH_type-1:0] typ;
        logic [WIDTH_add-1:0]  src;
        logic [WIDTH_add-1:0]  dst;
        logic [WIDTH_data-1:0] data;
    } pkt_t;

    localparam logic [WIDTH_add-1:0] MY_ADDR = WIDTH_add'(LOCAL_ADDR);

    pkt_t       tx_in, tx_head, rx_in, rx_head, net_in_pkt;
    logic       tx_push, tx_pop, tx_full, tx_empty;
    logic       rx_push, rx_pop, rx_full, rx_empty;
    logic       net_in_hs, net_in_hit;
    logic       tx_self, loop_mv;
    logic [7:0] drop_q;

    // ---------------- TX path ----------------
    assign bus.pe_tx_ready = rst_n && !tx_full;
    assign tx_push         = bus.pe_tx_valid && bus.pe_tx_ready;
    assign tx_in           = '{typ:  bus.pe_tx_type,
                               src:  MY_ADDR,
                               dst:  bus.pe_tx_dest,
                               data: bus.pe_tx_data};

    noc_leaf_fifo #(.DEPTH(TX_DEPTH), .W(WIDTH_pack)) u_tx_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (tx_push),
        .din   (tx_in),
        .pop   (tx_pop),
        .dout  (tx_head),
        .full  (tx_full),
        .empty (tx_empty)
    );

    // ---------------- RX path ----------------
    assign net_in_pkt       = pkt_t'(bus.net_in_pack);
    assign bus.net_in_ready = rst_n && !rx_full;
    assign net_in_hs        = bus.net_in_valid && bus.net_in_ready;
    assign net_in_hit       = net_in_hs && (net_in_pkt.dst == MY_ADDR);

`ifdef NOC_LEAF_LOOPBACK_EN
    // A self-addressed head is withheld from the network and slips into the
    // RX FIFO only in a cycle the router is not delivering, so network
    // traffic always wins the RX write port.
    assign tx_self = !tx_empty && (tx_head.dst == MY_ADDR);
    assign loop_mv = tx_self && !rx_full && !net_in_hs;
`else
    assign tx_self = 1'b0;
    assign loop_mv = 1'b0;
`endif

    assign bus.net_out_valid = !tx_empty && !tx_self;
    assign bus.net_out_pack  = bus.net_out_valid ? tx_head : '0;
    assign tx_pop            = (bus.net_out_valid && bus.net_out_ready) || loop_mv;

    assign rx_push = net_in_hit || loop_mv;
    assign rx_in   = net_in_hit ? net_in_pkt : tx_head;

    noc_leaf_fifo #(.DEPTH(RX_DEPTH), .W(WIDTH_pack)) u_rx_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (rx_push),
        .din   (rx_in),
        .pop   (rx_pop),
        .dout  (rx_head),
        .full  (rx_full),
        .empty (rx_empty)
    );

    assign bus.pe_rx_valid = !rx_empty;
    assign rx_pop          = bus.pe_rx_valid && bus.pe_rx_ready;
    // Zero the fields while empty so reset and idle look identical to the PE.
    assign bus.pe_rx_src   = rx_empty ? '0 : rx_head.src;
    assign bus.pe_rx_type  = rx_empty ? '0 : rx_head.typ;
    assign bus.pe_rx_data  = rx_empty ? '0 : rx_head.data;

    // ---------------- misroute counter ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_q <= '0;
        end else if (net_in_hs && !net_in_hit && (drop_q != 8'hFF)) begin
            drop_q <= drop_q + 8'd1;
        end
    end

    assign bus.drop_cnt = drop_q;
endmodule

// File: tb/tb_noc_leaf_interface.sv
// ---------------------------------------------------------------------------
// tb_noc_leaf_interface
// Directed bench for noc_leaf_interface with LOCAL_ADDR=1, depth 4 FIFOs.
// Inputs change 1 time unit after the rising edge; outputs are sampled there.
// The loopback section is compiled only with NOC_LEAF_LOOPBACK_EN.
// ---------------------------------------------------------------------------
module tb_noc_leaf_interface;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    noc_leaf_interface_if bus ();

    noc_leaf_interface #(.LOCAL_ADDR(1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [19:0] mk(input logic [1:0] t, input logic [4:0] s,
                                       input logic [4:0] r, input logic [7:0] d);
        return {t, s, r, d};
    endfunction

    logic [19:0] exp_tx [4];
    logic [19:0] exp_rx [4];

    initial begin
        bus.pe_tx_valid   = 1'b0;
        bus.pe_tx_dest    = '0;
        bus.pe_tx_type    = '0;
        bus.pe_tx_data    = '0;
        bus.net_out_ready = 1'b0;
        bus.net_in_valid  = 1'b0;
        bus.net_in_pack   = '0;
        bus.pe_rx_ready   = 1'b0;

        // ---- reset state ----
        #1;
        chk("rst_tx_ready",  bus.pe_tx_ready, 0);
        chk("rst_in_ready",  bus.net_in_ready, 0);
        chk("rst_out_valid", bus.net_out_valid, 0);
        chk("rst_rx_valid",  bus.pe_rx_valid, 0);
        chk("rst_out_pack",  bus.net_out_pack, 0);
        chk("rst_drop",      bus.drop_cnt, 0);
        tick(); tick();
        rst_n = 1'b1;
        #1;
        chk("post_rst_tx_ready", bus.pe_tx_ready, 1);
        chk("post_rst_in_ready", bus.net_in_ready, 1);

        // ---- single TX packet, held under backpressure ----
        bus.pe_tx_valid = 1'b1;
        bus.pe_tx_dest  = 5'd5;
        bus.pe_tx_type  = 2'b01;
        bus.pe_tx_data  = 8'hA5;
        #1;
        chk("tx_no_bypass", bus.net_out_valid, 0);
        tick();
        bus.pe_tx_valid = 1'b0;
        chk("tx1_valid", bus.net_out_valid, 1);
        chk("tx1_pack",  bus.net_out_pack, 20'h425A5);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("tx1_hold_valid", bus.net_out_valid, 1);
            chk("tx1_hold_pack",  bus.net_out_pack, 20'h425A5);
        end
        bus.net_out_ready = 1'b1;
        tick();
        bus.net_out_ready = 1'b0;
        chk("tx1_popped", bus.net_out_valid, 0);

        // ---- fill TX FIFO, then drain in order ----
        for (int i = 0; i < 4; i++) begin
            exp_tx[i] = mk(2'(i), 5'd1, 5'(i + 2), 8'(8'h10 + i));
            bus.pe_tx_valid = 1'b1;
            bus.pe_tx_type  = 2'(i);
            bus.pe_tx_dest  = 5'(i + 2);
            bus.pe_tx_data  = 8'(8'h10 + i);
            tick();
            if (i == 2) chk("tx_ready_at3", bus.pe_tx_ready, 1);
        end
        chk("tx_full_ready", bus.pe_tx_ready, 0);
        // Held request while full must not be absorbed.
        bus.pe_tx_data = 8'hEE;
        tick();
        bus.pe_tx_valid = 1'b0;
        chk("tx_full_hold", bus.pe_tx_ready, 0);
        bus.net_out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("tx_order_valid", bus.net_out_valid, 1);
            chk("tx_order_pack",  bus.net_out_pack, exp_tx[i]);
            tick();
            if (i == 0) chk("tx_ready_after_pop", bus.pe_tx_ready, 1);
        end
        bus.net_out_ready = 1'b0;
        chk("tx_drained", bus.net_out_valid, 0);

        // ---- RX accept and misroute ----
        bus.net_in_valid = 1'b1;
        bus.net_in_pack  = mk(2'b10, 5'd9, 5'd1, 8'h3C);
        #1;
        chk("rx_no_bypass", bus.pe_rx_valid, 0);
        tick();
        bus.net_in_valid = 1'b0;
        chk("rx1_valid", bus.pe_rx_valid, 1);
        chk("rx1_src",   bus.pe_rx_src, 9);
        chk("rx1_type",  bus.pe_rx_type, 2);
        chk("rx1_data",  bus.pe_rx_data, 8'h3C);
        bus.pe_rx_ready = 1'b1;
        tick();
        bus.pe_rx_ready = 1'b0;
        chk("rx1_popped", bus.pe_rx_valid, 0);

        bus.net_in_valid = 1'b1;
        bus.net_in_pack  = mk(2'b00, 5'd9, 5'd7, 8'h55);
        tick();
        chk("drop_no_valid", bus.pe_rx_valid, 0);
        chk("drop_one",      bus.drop_cnt, 1);
        repeat (253) tick();
        chk("drop_254", bus.drop_cnt, 254);
        tick();
        chk("drop_255", bus.drop_cnt, 255);
        repeat (46) tick();
        bus.net_in_valid = 1'b0;
        chk("drop_sat", bus.drop_cnt, 255);
        chk("drop_rx_empty", bus.pe_rx_valid, 0);

        // ---- fill RX FIFO, then drain in order ----
        for (int i = 0; i < 4; i++) begin
            exp_rx[i] = mk(2'(i), 5'(i + 3), 5'd1, 8'(8'h40 + i));
            bus.net_in_valid = 1'b1;
            bus.net_in_pack  = exp_rx[i];
            tick();
            if (i == 2) chk("rx_ready_at3", bus.net_in_ready, 1);
        end
        chk("rx_full_ready", bus.net_in_ready, 0);
        bus.net_in_pack = mk(2'b11, 5'd2, 5'd1, 8'hEE);
        tick();
        bus.net_in_valid = 1'b0;
        chk("rx_full_drop_unchanged", bus.drop_cnt, 255);
        bus.pe_rx_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("rx_order_valid", bus.pe_rx_valid, 1);
            chk("rx_order_src",   bus.pe_rx_src, exp_rx[i][17:13]);
            chk("rx_order_data",  bus.pe_rx_data, exp_rx[i][7:0]);
            tick();
            if (i == 0) chk("rx_ready_after_pop", bus.net_in_ready, 1);
        end
        bus.pe_rx_ready = 1'b0;
        chk("rx_drained", bus.pe_rx_valid, 0);

        // ---- concurrent TX and RX, then reset mid-burst ----
        for (int i = 0; i < 2; i++) begin
            bus.pe_tx_valid  = 1'b1;
            bus.pe_tx_type   = 2'b10;
            bus.pe_tx_dest   = 5'd3;
            bus.pe_tx_data   = 8'(8'h60 + i);
            bus.net_in_valid = 1'b1;
            bus.net_in_pack  = mk(2'b01, 5'd4, 5'd1, 8'(8'h70 + i));
            tick();
        end
        bus.pe_tx_valid  = 1'b0;
        bus.net_in_valid = 1'b0;
        chk("both_tx_valid", bus.net_out_valid, 1);
        chk("both_tx_pack",  bus.net_out_pack, mk(2'b10, 5'd1, 5'd3, 8'h60));
        chk("both_rx_valid", bus.pe_rx_valid, 1);
        chk("both_rx_data",  bus.pe_rx_data, 8'h70);
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", bus.net_out_valid, 0);
        chk("midrst_rx_valid",  bus.pe_rx_valid, 0);
        chk("midrst_tx_ready",  bus.pe_tx_ready, 0);
        chk("midrst_in_ready",  bus.net_in_ready, 0);
        chk("midrst_out_pack",  bus.net_out_pack, 0);
        chk("midrst_rx_data",   bus.pe_rx_data, 0);
        chk("midrst_drop",      bus.drop_cnt, 0);
        tick();
        rst_n = 1'b1;
        #1;
        chk("after_rst_out_valid", bus.net_out_valid, 0);
        chk("after_rst_rx_valid",  bus.pe_rx_valid, 0);
        chk("after_rst_tx_ready",  bus.pe_tx_ready, 1);
        chk("after_rst_drop",      bus.drop_cnt, 0);
        bus.pe_tx_valid = 1'b1;
        bus.pe_tx_type  = 2'b11;
        bus.pe_tx_dest  = 5'd6;
        bus.pe_tx_data  = 8'h99;
        tick();
        bus.pe_tx_valid = 1'b0;
        chk("after_rst_fresh", bus.net_out_pack, mk(2'b11, 5'd1, 5'd6, 8'h99));
        bus.net_out_ready = 1'b1;
        tick();
        bus.net_out_ready = 1'b0;
        chk("after_rst_empty", bus.net_out_valid, 0);

`ifdef NOC_LEAF_LOOPBACK_EN
        // ---- loopback: self-addressed packet never reaches the network ----
        bus.pe_tx_valid = 1'b1;
        bus.pe_tx_type  = 2'b11;
        bus.pe_tx_dest  = 5'd1;
        bus.pe_tx_data  = 8'h77;
        bus.net_out_ready = 1'b1;
        tick();
        bus.pe_tx_valid = 1'b0;
        chk("lb_not_out1", bus.net_out_valid, 0);
        chk("lb_rx_early", bus.pe_rx_valid, 0);
        tick();
        chk("lb_not_out2", bus.net_out_valid, 0);
        chk("lb_rx_valid", bus.pe_rx_valid, 1);
        chk("lb_rx_src",   bus.pe_rx_src, 1);
        chk("lb_rx_data",  bus.pe_rx_data, 8'h77);
        chk("lb_no_drop",  bus.drop_cnt, 0);
        bus.pe_rx_ready = 1'b1;
        tick();
        bus.pe_rx_ready = 1'b0;

        // Network packet arriving while a loopback is pending goes first.
        bus.pe_tx_valid = 1'b1;
        bus.pe_tx_data  = 8'h11;
        tick();
        bus.pe_tx_valid  = 1'b0;
        bus.net_in_valid = 1'b1;
        bus.net_in_pack  = mk(2'b00, 5'd9, 5'd1, 8'h22);
        tick();
        bus.net_in_valid = 1'b0;
        chk("lb_pri_head", bus.pe_rx_data, 8'h22);
        tick();
        chk("lb_pri_hold", bus.pe_rx_data, 8'h22);
        bus.pe_rx_ready = 1'b1;
        tick();
        chk("lb_pri_second_src",  bus.pe_rx_src, 1);
        chk("lb_pri_second_data", bus.pe_rx_data, 8'h11);
        tick();
        bus.pe_rx_ready = 1'b0;
        bus.net_out_ready = 1'b0;
        chk("lb_pri_empty", bus.pe_rx_valid, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
